// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB arbitration types and constants: port-owner record, requester slots,
// default CDB port count.
package cdb_arbiter_pkg;

    localparam int CDB_NUM_PORTS = 2;
    localparam int CDB_IDX_MAX_W = 8;

    // Fixed requester slots on the CDB
    localparam int REQ_ALU0 = 0;
    localparam int REQ_ALU1 = 1;
    localparam int REQ_MUL  = 2;
    localparam int REQ_LSU  = 3;

    typedef struct packed {
        logic                     valid;
        logic [CDB_IDX_MAX_W-1:0] idx;
    } cdb_port_t;

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational circular first-K selector: scans req & ~mask from start and
// returns up to K picked indices in scan order.
module rr_pick #(
    parameter int N     = 4,
    parameter int K     = 2,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]            req,
    input  logic [IDX_W-1:0]        start,
    input  logic [N-1:0]            mask,
    output logic [K-1:0]            pick_vld,
    output logic [K-1:0][IDX_W-1:0] pick_idx
);

    always_comb begin
        int cnt;
        int idx;
        logic [IDX_W-1:0] ii;
        pick_vld = '0;
        pick_idx = '0;
        cnt      = 0;
        idx      = 0;
        ii       = '0;
        for (int off = 0; off < N; off++) begin
            idx = int'(start) + off;
            if (idx >= N) idx = idx - N;
            ii = IDX_W'(idx);
            if (req[ii] && !mask[ii] && cnt < K) begin
                // slot index compared against constants keeps every select static
                for (int k = 0; k < K; k++) begin
                    if (k == cnt) begin
                        pick_vld[k] = 1'b1;
                        pick_idx[k] = ii;
                    end
                end
                cnt = cnt + 1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: same-cycle grant, registered port-ownership map for the broadcast cycle.
// Define CDB_ARB_STARVE_EN to build starvation counters with promoted-first priority.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int NUM_PORTS    = CDB_NUM_PORTS,
    parameter int STARVE_LIMIT = 7,
    parameter int IDX_W        = $clog2(NUM_REQ)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req,
    output logic [NUM_REQ-1:0]              grant,
    output logic [NUM_PORTS-1:0]            port_valid,
    output logic [NUM_PORTS-1:0][IDX_W-1:0] port_owner,
    output logic [IDX_W-1:0]                rr_ptr_o
);

    logic [IDX_W-1:0]                rr_ptr;
    logic [NUM_REQ-1:0]              promo;
    logic [NUM_PORTS-1:0]            pr_vld, rr_vld;
    logic [NUM_PORTS-1:0][IDX_W-1:0] pr_idx, rr_idx;
    cdb_port_t [NUM_PORTS-1:0]       port_nxt;
    logic                            rr_any;
    logic [IDX_W-1:0]                rr_last;
    logic                            unused_port_bits;

`ifdef CDB_ARB_STARVE_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [NUM_REQ-1:0][CNT_W-1:0] starve_cnt;

    always_comb begin
        promo = '0;
        for (int i = 0; i < NUM_REQ; i++)
            promo[i] = req[i] && (starve_cnt[i] >= CNT_W'(STARVE_LIMIT));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req[i] || grant[i])
                    starve_cnt[i] <= '0;
                else if (starve_cnt[i] < CNT_W'(STARVE_LIMIT))
                    starve_cnt[i] <= starve_cnt[i] + CNT_W'(1);
            end
        end
    end
`else
    localparam int UNUSED_STARVE_LIMIT = STARVE_LIMIT;
    assign promo = '0;
`endif

    rr_pick #(.N(NUM_REQ), .K(NUM_PORTS), .IDX_W(IDX_W)) u_promo_pick (
        .req      (promo),
        .start    ('0),
        .mask     ('0),
        .pick_vld (pr_vld),
        .pick_idx (pr_idx)
    );

    // promoted requesters are taken out of the circular pass entirely
    rr_pick #(.N(NUM_REQ), .K(NUM_PORTS), .IDX_W(IDX_W)) u_rr_pick (
        .req      (req),
        .start    (rr_ptr),
        .mask     (promo),
        .pick_vld (rr_vld),
        .pick_idx (rr_idx)
    );

    always_comb begin
        int slot;
        port_nxt = '0;
        grant    = '0;
        rr_any   = 1'b0;
        rr_last  = '0;
        slot     = 0;
        for (int q = 0; q < NUM_PORTS; q++) begin
            if (pr_vld[q]) begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (p == slot) begin
                        port_nxt[p].valid = 1'b1;
                        port_nxt[p].idx   = CDB_IDX_MAX_W'(pr_idx[q]);
                    end
                end
                slot = slot + 1;
            end
        end
        for (int q = 0; q < NUM_PORTS; q++) begin
            if (rr_vld[q]) begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (p == slot) begin
                        port_nxt[p].valid = 1'b1;
                        port_nxt[p].idx   = CDB_IDX_MAX_W'(rr_idx[q]);
                        rr_any            = 1'b1;
                        rr_last           = rr_idx[q];
                    end
                end
                slot = slot + 1;
            end
        end
        for (int p = 0; p < NUM_PORTS; p++)
            if (port_nxt[p].valid) grant[port_nxt[p].idx[IDX_W-1:0]] = 1'b1;
        if (reset) grant = '0;
    end

    assign unused_port_bits = ^port_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            port_valid <= '0;
            port_owner <= '0;
            rr_ptr     <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                port_valid[p] <= port_nxt[p].valid;
                port_owner[p] <= port_nxt[p].idx[IDX_W-1:0];
            end
            if (rr_any)
                rr_ptr <= (rr_last == IDX_W'(NUM_REQ - 1)) ? '0 : rr_last + IDX_W'(1);
        end
    end

    assign rr_ptr_o = rr_ptr;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: vector table with a one-deep broadcast scoreboard, reset corners,
// and (with CDB_ARB_STARVE_EN) a single-port starvation sequence.
module tb_cdb_arbiter;

    logic             clock = 1'b0;
    logic             reset;
    logic [3:0]       req;
    logic [3:0]       grant;
    logic [1:0]       port_valid;
    logic [1:0][1:0]  port_owner;
    logic [1:0]       rr_ptr_o;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    cdb_arbiter #(.NUM_REQ(4), .NUM_PORTS(2), .STARVE_LIMIT(7)) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .grant      (grant),
        .port_valid (port_valid),
        .port_owner (port_owner),
        .rr_ptr_o   (rr_ptr_o)
    );

`ifdef CDB_ARB_STARVE_EN
    logic [3:0] req_s;
    logic [3:0] grant_s;
    logic [0:0] pv_s;
    logic [0:0][1:0] po_s;
    logic [1:0] ptr_s;

    cdb_arbiter #(.NUM_REQ(4), .NUM_PORTS(1), .STARVE_LIMIT(2)) dut_s (
        .clock      (clock),
        .reset      (reset),
        .req        (req_s),
        .grant      (grant_s),
        .port_valid (pv_s),
        .port_owner (po_s),
        .rr_ptr_o   (ptr_s)
    );
`endif

    typedef struct {
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] pv;
        logic [1:0] o0;
        logic [1:0] o1;
        logic [1:0] ptr;
    } vec_t;

    typedef struct {
        logic [1:0] pv;
        logic [3:0] own;
        logic [1:0] ptr;
    } bcast_t;

    vec_t   vecs[15];
    bcast_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic pop_check(input int row);
        bcast_t e;
        if (sb.size() == 0) begin
            chk($sformatf("sb_empty_r%0d", row), 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk($sformatf("pv_r%0d", row),  {30'd0, port_valid}, {30'd0, e.pv});
            chk($sformatf("own_r%0d", row), {28'd0, port_owner[1], port_owner[0]}, {28'd0, e.own});
            chk($sformatf("ptr_r%0d", row), {30'd0, rr_ptr_o}, {30'd0, e.ptr});
        end
    endtask

    initial begin
        vecs[0]  = '{4'b0000, 4'b0000, 2'b00, 2'd0, 2'd0, 2'd0};
        vecs[1]  = '{4'b0000, 4'b0000, 2'b00, 2'd0, 2'd0, 2'd0};
        vecs[2]  = '{4'b0000, 4'b0000, 2'b00, 2'd0, 2'd0, 2'd0};
        vecs[3]  = '{4'b1111, 4'b0011, 2'b11, 2'd0, 2'd1, 2'd2};
        vecs[4]  = '{4'b1111, 4'b1100, 2'b11, 2'd2, 2'd3, 2'd0};
        vecs[5]  = '{4'b1111, 4'b0011, 2'b11, 2'd0, 2'd1, 2'd2};
        vecs[6]  = '{4'b1111, 4'b1100, 2'b11, 2'd2, 2'd3, 2'd0};
        vecs[7]  = '{4'b0100, 4'b0100, 2'b01, 2'd2, 2'd0, 2'd3};
        vecs[8]  = '{4'b1001, 4'b1001, 2'b11, 2'd3, 2'd0, 2'd1};
        vecs[9]  = '{4'b0010, 4'b0010, 2'b01, 2'd1, 2'd0, 2'd2};
        vecs[10] = '{4'b1101, 4'b1100, 2'b11, 2'd2, 2'd3, 2'd0};
        vecs[11] = '{4'b1011, 4'b0011, 2'b11, 2'd0, 2'd1, 2'd2};
        vecs[12] = '{4'b0110, 4'b0110, 2'b11, 2'd2, 2'd1, 2'd2};
        vecs[13] = '{4'b0000, 4'b0000, 2'b00, 2'd0, 2'd0, 2'd2};
        vecs[14] = '{4'b0001, 4'b0001, 2'b01, 2'd0, 2'd0, 2'd1};

        reset = 1'b1;
        req   = '0;
`ifdef CDB_ARB_STARVE_EN
        req_s = '0;
`endif
        // grant must stay low while reset is held, even with requests pending
        @(negedge clock);
        req = 4'b1111;
        #1 chk("rst_grant", {28'd0, grant}, 32'd0);
        @(negedge clock);
        chk("rst_pv",  {30'd0, port_valid}, 32'd0);
        chk("rst_own", {28'd0, port_owner[1], port_owner[0]}, 32'd0);
        chk("rst_ptr", {30'd0, rr_ptr_o}, 32'd0);
        reset = 1'b0;

        for (int r = 0; r < 15; r++) begin
            req = vecs[r].req;
            #1 chk($sformatf("grant_r%0d", r), {28'd0, grant}, {28'd0, vecs[r].grant});
            sb.push_back('{vecs[r].pv, {vecs[r].o1, vecs[r].o0}, vecs[r].ptr});
            @(negedge clock);
            pop_check(r);
        end

        // reset in the same cycle as a grantable request: grant dropped, no broadcast
        req   = 4'b0011;
        reset = 1'b1;
        #1 chk("midrst_grant", {28'd0, grant}, 32'd0);
        @(negedge clock);
        chk("midrst_pv",  {30'd0, port_valid}, 32'd0);
        chk("midrst_ptr", {30'd0, rr_ptr_o}, 32'd0);
        reset = 1'b0;
        req   = '0;
        @(negedge clock);
        chk("post_rst_pv", {30'd0, port_valid}, 32'd0);

`ifdef CDB_ARB_STARVE_EN
        begin
            int won_at;
            won_at = -1;
            for (int c = 0; c < 6 && won_at < 0; c++) begin
                req_s = 4'b1011;
                #1;
                if (grant_s[3]) won_at = c;
                @(negedge clock);
            end
            req_s = '0;
            chk("starve_bound", {31'd0, (won_at >= 0 && won_at <= 2)}, 32'd1);
            chk("starve_cnt_clr", {30'd0, dut_s.starve_cnt[3]}, 32'd0);
            chk("starve_pv", {31'd0, pv_s[0]}, 32'd1);
            chk("starve_owner", {30'd0, po_s[0]}, 32'd3);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
